// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: receive FSM states,
// oversampling ratios and word-length codes.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam int unsigned OSR16 = 16;
   localparam int unsigned OSR13 = 13;
   localparam int unsigned MID16 = 8;
   localparam int unsigned MID13 = 6;

   localparam logic [1:0] WLS_5 = 2'b00;
   localparam logic [1:0] WLS_6 = 2'b01;
   localparam logic [1:0] WLS_7 = 2'b10;
   localparam logic [1:0] WLS_8 = 2'b11;

   function automatic logic [2:0] last_bit_idx(input logic [1:0] wls);
      last_bit_idx = 3'd7;
      unique case (wls)
         WLS_5: last_bit_idx = 3'd4;
         WLS_6: last_bit_idx = 3'd5;
         WLS_7: last_bit_idx = 3'd6;
         WLS_8: last_bit_idx = 3'd7;
      endcase
   endfunction

   function automatic logic [3:0] osr_m1(input logic osm_sel);
      return osm_sel ? 4'(OSR13 - 1) : 4'(OSR16 - 1);
   endfunction

   function automatic logic [3:0] mid_m1(input logic osm_sel);
      return osm_sel ? 4'(MID13 - 1) : 4'(MID16 - 1);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-stage synchroniser for the asynchronous serial input; resets to the
// idle (high) line level so no false start is seen after reset.
module uart_rx_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic rx_i,
   output logic rxs_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      end
   end

   assign rxs_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, start/data/parity/stop deframing
// and a single-cycle write strobe into the RX FIFO.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_clk,
   input  logic       BGE,
   input  logic       OSM_SEL,
   input  logic       PEN,
   input  logic       EPS,
   input  logic       STB,
   input  logic [1:0] WLS,
   input  logic       UART_RX_I,
   input  logic       rx_full_status,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       break_int,
   output logic       overrun_err
);

   logic       rxs;
   rx_state_t  state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shreg_q, shreg_d;
   logic       par_q, par_d;
   logic [3:0] osr_m1_q, osr_m1_d;
   logic [3:0] mid_m1_q, mid_m1_d;
   logic [2:0] last_q, last_d;
   logic       pen_q, pen_d;
   logic       eps_q, eps_d;

   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       parity_err_q, parity_err_d;
   logic       frame_err_q, frame_err_d;
   logic       break_q, break_d;
   logic       overrun_q, overrun_d;

   logic       stop_sample;
   logic       unused_stb;

   // The second stop bit is ordinary idle line to the receiver.
   assign unused_stb = STB;

   uart_rx_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_i(clk),
      .rst_i(rst),
      .rx_i (UART_RX_I),
      .rxs_o(rxs)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shreg_q      <= '0;
         par_q        <= 1'b0;
         osr_m1_q     <= '0;
         mid_m1_q     <= '0;
         last_q       <= '0;
         pen_q        <= 1'b0;
         eps_q        <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         break_q      <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shreg_q      <= shreg_d;
         par_q        <= par_d;
         osr_m1_q     <= osr_m1_d;
         mid_m1_q     <= mid_m1_d;
         last_q       <= last_d;
         pen_q        <= pen_d;
         eps_q        <= eps_d;
         rx_data_q    <= rx_data_d;
         rx_valid_q   <= rx_valid_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         break_q      <= break_d;
         overrun_q    <= overrun_d;
      end
   end

   // Line control is captured at start detection and held for the whole frame.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      par_d    = par_q;
      osr_m1_d = osr_m1_q;
      mid_m1_d = mid_m1_q;
      last_d   = last_q;
      pen_d    = pen_q;
      eps_d    = eps_q;
      if (!BGE) begin
         state_d = IDLE;
      end else if (baud_clk) begin
         unique case (state_q)
            IDLE: begin
               if (!rxs) begin
                  state_d  = START;
                  cnt_d    = '0;
                  bit_d    = '0;
                  shreg_d  = '0;
                  par_d    = 1'b0;
                  osr_m1_d = osr_m1(OSM_SEL);
                  mid_m1_d = mid_m1(OSM_SEL);
                  last_d   = last_bit_idx(WLS);
                  pen_d    = PEN;
                  eps_d    = EPS;
               end
            end
            START: begin
               if (cnt_q == mid_m1_q) begin
                  cnt_d   = '0;
                  state_d = rxs ? IDLE : DATA;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            DATA: begin
               if (cnt_q == osr_m1_q) begin
                  cnt_d          = '0;
                  shreg_d[bit_q] = rxs;
                  if (bit_q == last_q) begin
                     state_d = pen_q ? PARITY : STOP;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            PARITY: begin
               if (cnt_q == osr_m1_q) begin
                  cnt_d   = '0;
                  par_d   = rxs;
                  state_d = STOP;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            STOP: begin
               if (cnt_q == osr_m1_q) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign stop_sample = BGE && baud_clk && (state_q == STOP) && (cnt_q == osr_m1_q);

   always_comb begin
      rx_data_d    = rx_data_q;
      rx_valid_d   = 1'b0;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      break_d      = break_q;
      overrun_d    = 1'b0;
      if (stop_sample) begin
         if (!rx_full_status) begin
            rx_valid_d   = 1'b1;
            rx_data_d    = shreg_q;
            parity_err_d = pen_q && ((^{shreg_q, par_q}) == eps_q);
            frame_err_d  = ~rxs;
            break_d      = (shreg_q == '0) && !par_q && !rxs;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign parity_err  = parity_err_q;
   assign frame_err   = frame_err_q;
   assign break_int   = break_q;
   assign overrun_err = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a behavioural serial driver and frame model
// generate the line and the expected characters and flags.
module tb_uart_rx;

   localparam int DIV = 5;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      logic       bi;
   } rec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       baud_clk;
   logic       BGE;
   logic       OSM_SEL;
   logic       PEN;
   logic       EPS;
   logic       STB;
   logic [1:0] WLS;
   logic       UART_RX_I;
   logic       rx_full_status;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;
   logic       break_int;
   logic       overrun_err;

   int   n_checks  = 0;
   int   n_pass    = 0;
   int   n_overrun = 0;
   int   div_cnt   = 0;
   rec_t got_q[$];

   uart_rx #(
      .SYNC_STAGES(2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .baud_clk      (baud_clk),
      .BGE           (BGE),
      .OSM_SEL       (OSM_SEL),
      .PEN           (PEN),
      .EPS           (EPS),
      .STB           (STB),
      .WLS           (WLS),
      .UART_RX_I     (UART_RX_I),
      .rx_full_status(rx_full_status),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .parity_err    (parity_err),
      .frame_err     (frame_err),
      .break_int     (break_int),
      .overrun_err   (overrun_err)
   );

   always #5 clk = ~clk;

   initial begin
      baud_clk = 1'b0;
      forever begin
         @(negedge clk);
         baud_clk = (div_cnt == DIV - 1);
         div_cnt  = (div_cnt == DIV - 1) ? 0 : div_cnt + 1;
      end
   end

   // Every clk with a strobe high is logged, so a stretched pulse shows up as an extra entry.
   always @(negedge clk) begin
      if (rx_valid === 1'b1) got_q.push_back({rx_data, parity_err, frame_err, break_int});
      if (overrun_err === 1'b1) n_overrun++;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   function automatic int osr();
      return OSM_SEL ? 13 : 16;
   endfunction

   function automatic logic good_par(input logic [7:0] d);
      int nb = 5 + int'(WLS);
      int c = 0;
      for (int i = 0; i < nb; i++) c += (int'(d) >> i) % 2;
      return EPS ? (c % 2 == 1) : (c % 2 == 0);
   endfunction

   function automatic rec_t model(input logic [7:0] d, input logic parbit, input logic stopbit);
      int   nb = 5 + int'(WLS);
      int   dm = int'(d) % (1 << nb);
      int   c  = (PEN && parbit) ? 1 : 0;
      rec_t r;
      for (int i = 0; i < nb; i++) c += (dm >> i) % 2;
      r.d  = 8'(dm);
      r.pe = PEN && ((c % 2) != (EPS ? 0 : 1));
      r.fe = !stopbit;
      r.bi = (dm == 0) && !stopbit && (!PEN || !parbit);
      return r;
   endfunction

   task automatic idle_bits(input int n);
      repeat (n * osr() * DIV) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic parbit, input logic stopbit);
      int nb = 5 + int'(WLS);
      int bc = osr() * DIV;
      int lo = (osr() / 2 + 3) * DIV;
      @(negedge clk);
      UART_RX_I = 1'b0;
      repeat (bc) @(negedge clk);
      for (int i = 0; i < nb; i++) begin
         UART_RX_I = d[i];
         repeat (bc) @(negedge clk);
      end
      if (PEN) begin
         UART_RX_I = parbit;
         repeat (bc) @(negedge clk);
      end
      UART_RX_I = stopbit;
      // A low stop bit is released early so the tail is not mistaken for a new start.
      if (stopbit) begin
         repeat (bc) @(negedge clk);
      end else begin
         repeat (lo) @(negedge clk);
         UART_RX_I = 1'b1;
         repeat (bc - lo) @(negedge clk);
      end
      UART_RX_I = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; BGE = 1'b1; OSM_SEL = 1'b0; PEN = 1'b0; EPS = 1'b0; STB = 1'b0;
      WLS = 2'b11; UART_RX_I = 1'b1; rx_full_status = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (rx_data !== 8'h00) $display("FAIL reset_data: got %h, expected 00", rx_data);
      else n_pass++;
      n_checks++;
      if ({rx_valid, parity_err, frame_err, break_int, overrun_err} !== 5'b0)
         $display("FAIL reset_flags: got %b, expected 00000",
                  {rx_valid, parity_err, frame_err, break_int, overrun_err});
      else n_pass++;
      idle_bits(2);
      n_checks++;
      if (got_q.size() != 0) $display("FAIL idle_no_strobe: got %0d strobes, expected 0", got_q.size());
      else n_pass++;
   endtask

   task automatic test_frame_a5();
      rec_t e;
      got_q.delete();
      OSM_SEL = 1'b0; WLS = 2'b11; PEN = 1'b1; EPS = 1'b1;
      e = model(8'hA5, good_par(8'hA5), 1'b1);
      send_frame(8'hA5, good_par(8'hA5), 1'b1);
      idle_bits(1);
      n_checks++;
      if (got_q.size() != 1) $display("FAIL a5_count: got %0d strobes, expected 1", got_q.size());
      else n_pass++;
      n_checks++;
      if (got_q.size() < 1 || got_q[0] !== e || e !== {8'hA5, 3'b000})
         $display("FAIL a5_frame: got %h, expected %h", (got_q.size() > 0) ? got_q[0] : 'x, e);
      else n_pass++;
   endtask

   task automatic test_bad_parity();
      rec_t e;
      got_q.delete();
      e = model(8'h3C, 1'b1, 1'b1);
      send_frame(8'h3C, 1'b1, 1'b1);
      idle_bits(1);
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== e || !e.pe)
         $display("FAIL bad_parity: got n=%0d rec=%h, expected n=1 rec=%h", got_q.size(),
                  (got_q.size() > 0) ? got_q[0] : 'x, e);
      else n_pass++;
      n_checks++;
      if ({rx_data, parity_err} !== {8'h3C, 1'b1})
         $display("FAIL parity_hold: got data=%h pe=%b, expected data=3c pe=1", rx_data, parity_err);
      else n_pass++;
   endtask

   task automatic test_glitch();
      rec_t e;
      got_q.delete();
      @(negedge clk);
      UART_RX_I = 1'b0;
      repeat (4 * DIV) @(negedge clk);
      UART_RX_I = 1'b1;
      idle_bits(12);
      n_checks++;
      if (got_q.size() != 0) $display("FAIL glitch_reject: got %0d strobes, expected 0", got_q.size());
      else n_pass++;
      e = model(8'h55, good_par(8'h55), 1'b1);
      send_frame(8'h55, good_par(8'h55), 1'b1);
      idle_bits(1);
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== e)
         $display("FAIL glitch_next: got n=%0d rec=%h, expected n=1 rec=%h", got_q.size(),
                  (got_q.size() > 0) ? got_q[0] : 'x, e);
      else n_pass++;
   endtask

   task automatic test_stop_low();
      rec_t e1, e2;
      got_q.delete();
      e1 = model(8'h81, good_par(8'h81), 1'b0);
      send_frame(8'h81, good_par(8'h81), 1'b0);
      idle_bits(1);
      n_checks++;
      if ({frame_err, break_int} !== 2'b10)
         $display("FAIL stop_low_flags: got fe=%b bi=%b, expected fe=1 bi=0", frame_err, break_int);
      else n_pass++;
      e2 = model(8'h00, 1'b0, 1'b0);
      send_frame(8'h00, 1'b0, 1'b0);
      idle_bits(1);
      n_checks++;
      if ({frame_err, break_int} !== 2'b11)
         $display("FAIL break_flags: got fe=%b bi=%b, expected fe=1 bi=1", frame_err, break_int);
      else n_pass++;
      n_checks++;
      if (got_q.size() != 2 || got_q[0] !== e1 || got_q[1] !== e2)
         $display("FAIL stop_low_frames: got n=%0d, expected n=2 recs %h %h", got_q.size(), e1, e2);
      else n_pass++;
   endtask

   task automatic test_full_fifo();
      rec_t e;
      got_q.delete();
      n_overrun = 0;
      rx_full_status = 1'b1;
      send_frame(8'h12, good_par(8'h12), 1'b1);
      idle_bits(1);
      rx_full_status = 1'b0;
      n_checks++;
      if (got_q.size() != 0 || n_overrun != 1)
         $display("FAIL overrun: got strobes=%0d overruns=%0d, expected strobes=0 overruns=1",
                  got_q.size(), n_overrun);
      else n_pass++;
      n_checks++;
      if (rx_data !== 8'h00)
         $display("FAIL overrun_discard: got data=%h, expected 00 (previous character)", rx_data);
      else n_pass++;
      e = model(8'h34, good_par(8'h34), 1'b1);
      send_frame(8'h34, good_par(8'h34), 1'b1);
      idle_bits(1);
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== e || n_overrun != 1)
         $display("FAIL after_full: got n=%0d rec=%h, expected n=1 rec=%h", got_q.size(),
                  (got_q.size() > 0) ? got_q[0] : 'x, e);
      else n_pass++;
   endtask

   task automatic test_bge_abort();
      got_q.delete();
      @(negedge clk);
      UART_RX_I = 1'b0;
      repeat (3 * osr() * DIV) @(negedge clk);
      BGE = 1'b0;
      UART_RX_I = 1'b1;
      repeat (3) @(negedge clk);
      BGE = 1'b1;
      idle_bits(14);
      n_checks++;
      if (got_q.size() != 0 || n_overrun != 1)
         $display("FAIL bge_abort: got %0d strobes, expected 0", got_q.size());
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      rec_t exp_q[$];
      logic [7:0] d;
      got_q.delete();
      OSM_SEL = 1'b1; WLS = 2'b00; PEN = 1'b0; EPS = 1'b0;
      idle_bits(1);
      for (int i = 0; i < 8; i++) begin
         d = 8'($urandom);
         exp_q.push_back(model(d, 1'b0, 1'b1));
         send_frame(d, 1'b0, 1'b1);
      end
      idle_bits(1);
      n_checks++;
      if (got_q.size() != exp_q.size())
         $display("FAIL b2b_count: got %0d strobes, expected %0d", got_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i] || exp_q[i].d > 8'h1F)
            $display("FAIL b2b_frame%0d: got %h, expected %h", i,
                     (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
         else n_pass++;
      end
   endtask

   task automatic test_rst_abort();
      got_q.delete();
      @(negedge clk);
      UART_RX_I = 1'b0;
      repeat (3 * osr() * DIV) @(negedge clk);
      rst = 1'b1;
      UART_RX_I = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle_bits(10);
      n_checks++;
      if (got_q.size() != 0 || rx_data !== 8'h00)
         $display("FAIL rst_abort: got strobes=%0d data=%h, expected strobes=0 data=00",
                  got_q.size(), rx_data);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_frame_a5();
      test_bad_parity();
      test_glitch();
      test_stop_low();
      test_full_fifo();
      test_bge_abort();
      test_back_to_back();
      test_rst_abort();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
